pc_next_unit: RTL and testbench



---
 rtl/pc_next_unit.sv | 123 ++++++++++++
 tb/tb_pc_next_unit.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pc_next_unit.sv
// Program-counter sequencer: owns the architectural PC and selects sequential,
// branch/JAL or JALR next-fetch addresses, with stall hold and misaligned-target trap.
module pc_next_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'('h100),
    parameter int              IALIGN       = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic            redirect_jalr,
    input  logic [XLEN-1:0] redirect_base,
    input  logic [XLEN-1:0] redirect_imm,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            fetch_valid,
    output logic            trap_valid,
    output logic [XLEN-1:0] trap_badaddr
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HOLD = 2'd1,
        TRAP = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic        [XLEN-1:0] pending_target;
    logic        [XLEN-1:0] pending_nxt;
    logic        [XLEN-1:0] pc_nxt;
    logic        [XLEN-1:0] badaddr_nxt;
    logic signed [XLEN-1:0] imm_s;
    logic        [XLEN-1:0] target;
    logic                   target_bad;

    // Wrapping add; JALR clears bit 0 before the alignment check is applied.
    function automatic logic [XLEN-1:0] calc_target(
        input logic [XLEN-1:0]        base,
        input logic signed [XLEN-1:0] imm,
        input logic                   jalr
    );
        logic [XLEN-1:0] sum;
        sum = base + XLEN'(imm);
        if (jalr) begin
            sum[0] = 1'b0;
        end
        return sum;
    endfunction

    function automatic logic is_misaligned(input logic [XLEN-1:0] t);
        if (IALIGN == 16) begin
            return t[0];
        end
        return |t[1:0];
    endfunction

    assign imm_s      = redirect_imm;
    assign target     = calc_target(redirect_base, imm_s, redirect_jalr);
    assign target_bad = is_misaligned(target);
    assign pc_plus4   = pc + XLEN'(4);

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        pending_nxt = pending_target;
        badaddr_nxt = trap_badaddr;
        unique case (state)
            RUN: begin
                if (redirect_valid && target_bad) begin
                    pc_nxt      = TRAP_VECTOR;
                    badaddr_nxt = target;
                    state_nxt   = TRAP;
                end else if (redirect_valid && !stall) begin
                    pc_nxt = target;
                end else if (redirect_valid) begin
                    pending_nxt = target;
                    state_nxt   = HOLD;
                end else if (!stall) begin
                    pc_nxt = pc_plus4;
                end
            end
            HOLD: begin
                // Oldest redirect wins: younger redirects are squashed by it.
                if (!stall) begin
                    pc_nxt    = pending_target;
                    state_nxt = RUN;
                end
            end
            TRAP: begin
                if (!stall) begin
                    pc_nxt = TRAP_VECTOR + XLEN'(4);
                end
                state_nxt = RUN;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // State / output register stage
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= RUN;
            pc             <= RESET_VECTOR;
            pending_target <= '0;
            trap_badaddr   <= '0;
            fetch_valid    <= 1'b0;
            trap_valid     <= 1'b0;
        end else begin
            state          <= state_nxt;
            pc             <= pc_nxt;
            pending_target <= pending_nxt;
            trap_badaddr   <= badaddr_nxt;
            fetch_valid    <= (state_nxt == RUN);
            trap_valid     <= (state_nxt == TRAP);
        end
    end

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed bench for pc_next_unit: a 32-bit-aligned instance checked throughout and
// a 16-bit-aligned instance checked on the JALR case that only the former traps on.
module tb_pc_next_unit;

    localparam int XLEN = 32;

    logic            clock = 1'b0;
    logic            reset;
    logic            stall;
    logic            redirect_valid;
    logic            redirect_jalr;
    logic [XLEN-1:0] redirect_base;
    logic [XLEN-1:0] redirect_imm;

    logic [XLEN-1:0] pc_a, pc_plus4_a, trap_badaddr_a;
    logic            fetch_valid_a, trap_valid_a;
    logic [XLEN-1:0] pc_b, pc_plus4_b, trap_badaddr_b;
    logic            fetch_valid_b, trap_valid_b;

    int passed = 0;
    int total  = 0;

    always #5 clock = ~clock;

    pc_next_unit #(.XLEN(XLEN), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100), .IALIGN(32)) dut_a (
        .clock(clock), .reset(reset), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_jalr(redirect_jalr),
        .redirect_base(redirect_base), .redirect_imm(redirect_imm),
        .pc(pc_a), .pc_plus4(pc_plus4_a), .fetch_valid(fetch_valid_a),
        .trap_valid(trap_valid_a), .trap_badaddr(trap_badaddr_a)
    );

    pc_next_unit #(.XLEN(XLEN), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100), .IALIGN(16)) dut_b (
        .clock(clock), .reset(reset), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_jalr(redirect_jalr),
        .redirect_base(redirect_base), .redirect_imm(redirect_imm),
        .pc(pc_b), .pc_plus4(pc_plus4_b), .fetch_valid(fetch_valid_b),
        .trap_valid(trap_valid_b), .trap_badaddr(trap_badaddr_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic redir(input logic v, input logic j, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] i);
        redirect_valid = v;
        redirect_jalr  = j;
        redirect_base  = b;
        redirect_imm   = i;
    endtask

    task automatic chk_a(input string tag, input logic [XLEN-1:0] epc, input logic efv,
                         input logic etv);
        chk({tag, "_pc"}, 64'(pc_a), 64'(epc));
        chk({tag, "_fv"}, 64'(fetch_valid_a), 64'(efv));
        chk({tag, "_tv"}, 64'(trap_valid_a), 64'(etv));
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        redir(1'b0, 1'b0, '0, '0);
        tick();
        tick();
        chk_a("reset", 32'h0, 1'b0, 1'b0);
        chk("reset_bad", 64'(trap_badaddr_a), 64'h0);
        chk("reset_plus4", 64'(pc_plus4_a), 64'h4);

        // Release reset and run sequentially.
        reset = 1'b0;
        tick();
        chk_a("seq4", 32'h4, 1'b1, 1'b0);
        tick();
        chk_a("seq8", 32'h8, 1'b1, 1'b0);
        tick();
        chk_a("seq12", 32'hC, 1'b1, 1'b0);
        chk("seq12_plus4", 64'(pc_plus4_a), 64'h10);

        // Land on the top word, then wrap.
        redir(1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0000_000C);
        tick();
        chk_a("top", 32'hFFFF_FFFC, 1'b1, 1'b0);
        chk("top_plus4", 64'(pc_plus4_a), 64'h0);
        redir(1'b0, 1'b0, '0, '0);
        tick();
        chk_a("wrap", 32'h0, 1'b1, 1'b0);

        // Backward branch.
        redir(1'b1, 1'b0, 32'h40, 32'hFFFF_FFF0);
        tick();
        chk_a("branch", 32'h30, 1'b1, 1'b0);
        redir(1'b0, 1'b0, '0, '0);
        tick();
        chk_a("branch_seq", 32'h34, 1'b1, 1'b0);

        // JALR to 0x1002: misaligned for IALIGN=32, fine for IALIGN=16.
        redir(1'b1, 1'b1, 32'h1001, 32'h2);
        tick();
        chk_a("jalr_trap", 32'h100, 1'b0, 1'b1);
        chk("jalr_bad", 64'(trap_badaddr_a), 64'h1002);
        chk("jalr16_pc", 64'(pc_b), 64'h1002);
        chk("jalr16_tv", 64'(trap_valid_b), 64'h0);
        // A redirect during TRAP is ignored.
        redir(1'b1, 1'b0, 32'h500, 32'h0);
        tick();
        chk_a("trap_exit", 32'h104, 1'b1, 1'b0);
        chk("trap_bad_held", 64'(trap_badaddr_a), 64'h1002);

        // Stalled redirect: first target held, later ones ignored.
        stall = 1'b1;
        redir(1'b1, 1'b0, 32'h200, 32'h0);
        tick();
        chk_a("hold_enter", 32'h104, 1'b0, 1'b0);
        redir(1'b1, 1'b0, 32'h300, 32'h0);
        tick();
        chk_a("hold_2nd", 32'h104, 1'b0, 1'b0);
        redir(1'b1, 1'b0, 32'h7, 32'h0);
        tick();
        chk_a("hold_mis", 32'h104, 1'b0, 1'b0);
        stall = 1'b0;
        redir(1'b1, 1'b0, 32'h400, 32'h0);
        tick();
        chk_a("hold_exit", 32'h200, 1'b1, 1'b0);
        redir(1'b0, 1'b0, '0, '0);
        tick();
        chk_a("hold_seq", 32'h204, 1'b1, 1'b0);

        // Trap taken while stalled.
        stall = 1'b1;
        redir(1'b1, 1'b0, 32'h6, 32'h0);
        tick();
        chk_a("strap", 32'h100, 1'b0, 1'b1);
        chk("strap_bad", 64'(trap_badaddr_a), 64'h6);
        redir(1'b0, 1'b0, '0, '0);
        tick();
        chk_a("strap_run", 32'h100, 1'b1, 1'b0);
        tick();
        chk_a("strap_stall", 32'h100, 1'b1, 1'b0);
        stall = 1'b0;
        tick();
        chk_a("strap_exit", 32'h104, 1'b1, 1'b0);

        // Reset while holding a pending target discards it.
        stall = 1'b1;
        redir(1'b1, 1'b0, 32'h200, 32'h0);
        tick();
        chk_a("rhold", 32'h104, 1'b0, 1'b0);
        redir(1'b0, 1'b0, '0, '0);
        reset = 1'b1;
        tick();
        chk_a("rhold_rst", 32'h0, 1'b0, 1'b0);
        chk("rhold_bad", 64'(trap_badaddr_a), 64'h0);
        reset = 1'b0;
        stall = 1'b0;
        tick();
        chk_a("rhold_4", 32'h4, 1'b1, 1'b0);
        tick();
        chk_a("rhold_8", 32'h8, 1'b1, 1'b0);
        tick();
        chk_a("rhold_c", 32'hC, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
